// File: rtl/combo_lock_ctrl.sv
// combo_lock_ctrl
//   Input-side controller for the combination lock. Synchronises and
//   debounces the arm/submit push-buttons, samples the switch code, checks
//   it against the stored passcode and tracks remaining attempts. Drives the
//   status signals consumed by the 7-segment message driver.
//
// Ports
//   clk       in   1       system clock
//   rst_n     in   1       asynchronous active-low reset
//   sw        in   CODE_W  raw switch code (asynchronous)
//   arm_n     in   1       raw push-button, active-low: start session / relock
//   submit_n  in   1       raw push-button, active-low: submit sw as a try
//   en        out  1       1 while a session is in progress (ENTRY)
//   attempts  out  2       tries remaining
//   unlocked  out  1       1 in OPEN
//   denied    out  1       1 in DENIED
//   disp_sel  out  2       0=CLOSED, 1=TRYS REMAINING, 2=OPEN, 3=DENIED
module combo_lock_ctrl #(
  parameter int                CODE_W          = 6,
  parameter logic [CODE_W-1:0] PASSCODE        = 6'b101001,
  parameter int                MAX_ATTEMPTS    = 3,
  parameter int                DEBOUNCE_CYCLES = 1_000_000,
  parameter int                LOCKOUT_CYCLES  = 50_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CODE_W-1:0] sw,
  input  logic              arm_n,
  input  logic              submit_n,
  output logic              en,
  output logic [1:0]        attempts,
  output logic              unlocked,
  output logic              denied,
  output logic [1:0]        disp_sel
);

  localparam int         DCW     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int         LCW     = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam logic [1:0] ATT_MAX = 2'(MAX_ATTEMPTS);
  localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCKOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_CLOSED = 2'd0,
    ST_ENTRY  = 2'd1,
    ST_OPEN   = 2'd2,
    ST_DENIED = 2'd3
  } state_t;

  // index 0 = arm, index 1 = submit
  logic [1:0] btn_raw;
  logic [1:0] btn_pulse;

  assign btn_raw = {submit_n, arm_n};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_deb
      logic           meta_reg;
      logic           sync_reg;
      logic           prev_reg;
      logic           armed_reg;
      logic           pulse_reg;
      logic [DCW-1:0] cnt_reg;
      logic [DCW-1:0] cnt_next;

      // cnt_next = number of consecutive cycles the synced level has held,
      // including the current one; saturates at DEBOUNCE_CYCLES.
      always_comb begin
        cnt_next = cnt_reg;
        if (sync_reg != prev_reg)
          cnt_next = DCW'(1);
        else if (cnt_reg != DCW'(DEBOUNCE_CYCLES))
          cnt_next = cnt_reg + 1'b1;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          meta_reg  <= 1'b1;
          sync_reg  <= 1'b1;
          prev_reg  <= 1'b1;
          armed_reg <= 1'b1;
          pulse_reg <= 1'b0;
          cnt_reg   <= '0;
        end else begin
          meta_reg  <= btn_raw[gi];
          sync_reg  <= meta_reg;
          prev_reg  <= sync_reg;
          cnt_reg   <= cnt_next;
          pulse_reg <= 1'b0;
          // One pulse per press: firing disarms, a stable release re-arms.
          if (cnt_next == DCW'(DEBOUNCE_CYCLES)) begin
            if (!sync_reg && armed_reg) begin
              pulse_reg <= 1'b1;
              armed_reg <= 1'b0;
            end else if (sync_reg && !armed_reg) begin
              armed_reg <= 1'b1;
            end
          end
        end
      end

      assign btn_pulse[gi] = pulse_reg;
    end
  endgenerate

  logic [CODE_W-1:0] sw_meta_reg;
  logic [CODE_W-1:0] sw_sync_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta_reg <= '0;
      sw_sync_reg <= '0;
    end else begin
      sw_meta_reg <= sw;
      sw_sync_reg <= sw_meta_reg;
    end
  end

  state_t         state_reg;
  logic [LCW-1:0] lock_cnt_reg;

  // Outputs are assigned alongside every state transition so they always
  // reflect the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_CLOSED;
      attempts     <= ATT_MAX;
      en           <= 1'b0;
      unlocked     <= 1'b0;
      denied       <= 1'b0;
      disp_sel     <= 2'd0;
      lock_cnt_reg <= '0;
    end else begin
      case (state_reg)
        ST_CLOSED: begin
          if (btn_pulse[0]) begin
            state_reg <= ST_ENTRY;
            en        <= 1'b1;
            disp_sel  <= 2'd1;
          end
        end
        ST_ENTRY: begin
          // arm is ignored here, so a coincident arm pulse is simply dropped
          if (btn_pulse[1]) begin
            if (sw_sync_reg == PASSCODE) begin
              state_reg <= ST_OPEN;
              en        <= 1'b0;
              unlocked  <= 1'b1;
              disp_sel  <= 2'd2;
            end else if (attempts > 2'd1) begin
              attempts <= attempts - 2'd1;
            end else begin
              state_reg    <= ST_DENIED;
              attempts     <= 2'd0;
              en           <= 1'b0;
              denied       <= 1'b1;
              disp_sel     <= 2'd3;
              lock_cnt_reg <= '0;
            end
          end
        end
        ST_OPEN: begin
          if (btn_pulse[0]) begin
            state_reg <= ST_CLOSED;
            unlocked  <= 1'b0;
            disp_sel  <= 2'd0;
            attempts  <= ATT_MAX;
          end
        end
        ST_DENIED: begin
          if (lock_cnt_reg == LOCK_LAST) begin
            state_reg    <= ST_CLOSED;
            denied       <= 1'b0;
            disp_sel     <= 2'd0;
            attempts     <= ATT_MAX;
            lock_cnt_reg <= '0;
          end else begin
            lock_cnt_reg <= lock_cnt_reg + 1'b1;
          end
        end
        default: begin
          state_reg    <= ST_CLOSED;
          attempts     <= ATT_MAX;
          en           <= 1'b0;
          unlocked     <= 1'b0;
          denied       <= 1'b0;
          disp_sel     <= 2'd0;
          lock_cnt_reg <= '0;
        end
      endcase
    end
  end

endmodule
